// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end:
// scancodes, held-key bit positions and frame receiver states.
package ps2_pkg;
    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_W    = 8'h1D;
    localparam logic [7:0] SC_S    = 8'h1B;
    localparam logic [7:0] SC_UP   = 8'h75;
    localparam logic [7:0] SC_DN   = 8'h72;
    localparam logic [7:0] SC_OVR0 = 8'h00;
    localparam logic [7:0] SC_OVR1 = 8'hFF;

    localparam logic [1:0] KEY_W  = 2'd3;
    localparam logic [1:0] KEY_S  = 2'd2;
    localparam logic [1:0] KEY_UP = 2'd1;
    localparam logic [1:0] KEY_DN = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;
endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchroniser, clock glitch
// filter, 11-bit frame FSM with odd parity and inter-edge timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_clk,
    input  logic       key_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] csync_q, csync_d;
    logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
    logic                   filt_q, filt_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    rx_state_e              state_q, state_d;
    logic [2:0]             bits_q, bits_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [7:0]             byte_q, byte_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   fall;
    logic                   bit_in;
    logic                   csync;

    assign csync  = csync_q[SYNC_STAGES-1];
    assign bit_in = dsync_q[SYNC_STAGES-1];
    assign fall   = filt_q & ~filt_d;

    always_comb begin
        csync_d = {csync_q[SYNC_STAGES-2:0], key_clk};
        dsync_d = {dsync_q[SYNC_STAGES-2:0], key_data};
        filt_d  = filt_q;
        fcnt_d  = '0;
        // Level flips only after FILTER_LEN disagreeing samples in a row.
        if (csync != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = csync;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        par_d   = par_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (state_q == ST_IDLE || fall) begin
            tmr_d = '0;
        end else if (tmr_q != TW'(TIMEOUT_CYCLES)) begin
            tmr_d = tmr_q + 1'b1;
        end else begin
            tmr_d = tmr_q;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (fall && !bit_in) begin
                    state_d = ST_DATA;
                    bits_d  = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d = {bit_in, shift_q[7:1]};
                    bits_d  = bits_q + 1'b1;
                    if (bits_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = bit_in;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if ((^{shift_q, par_q}) && bit_in) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // An edge in the terminal-count cycle keeps the frame alive.
        if (state_q != ST_IDLE && !fall &&
            tmr_q == TW'(TIMEOUT_CYCLES)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csync_q <= '1;
            dsync_q <= '1;
            filt_q  <= 1'b1;
            fcnt_q  <= '0;
            state_q <= ST_IDLE;
            bits_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tmr_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            csync_q <= csync_d;
            dsync_q <= dsync_d;
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmr_q   <= tmr_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_err   = err_q;
endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end for pong: tracks make/break codes of
// W, S, Up and Down and exposes every received byte.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_clk,
    input  logic       key_data,
    output logic [3:0] keys,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic [3:0] keys_q, keys_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       hit;
    logic [1:0] idx;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .key_clk (key_clk),
        .key_data(key_data),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    always_comb begin
        hit = 1'b1;
        idx = KEY_W;
        case ({ext_q, rx_byte})
            {1'b0, SC_W}:  idx = KEY_W;
            {1'b0, SC_S}:  idx = KEY_S;
            {1'b1, SC_UP}: idx = KEY_UP;
            {1'b1, SC_DN}: idx = KEY_DN;
            default:       hit = 1'b0;
        endcase
    end

    always_comb begin
        keys_d = keys_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                // 00/FF is the keyboard's overrun report: drop all held keys.
                if (rx_byte == SC_OVR0 || rx_byte == SC_OVR1) begin
                    keys_d = '0;
                end else if (hit) begin
                    keys_d[idx] = ~brk_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            keys_q <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            keys_q <= keys_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
        end
    end

    assign keys       = keys_q;
    assign code       = rx_byte;
    assign code_valid = rx_valid;
    assign frame_err  = rx_err;
endmodule
